// File: rtl/adder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : adder_pkg
// Brief    : Shared state encoding and mode constants for the serial adder.
// Revision : 1.0
// ============================================================================
package adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage : adder_pkg
`default_nettype wire

// File: rtl/adder_digit.sv
`default_nettype none
// ============================================================================
// Module   : adder_digit
// Brief    : Combinational DIGIT-bit ripple adder built from full-adder cells.
// Revision : 1.0
// ============================================================================
module adder_digit #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co,
    output logic             c_top
);

    logic [DIGIT:0] w_c;

    assign w_c[0] = ci;

    generate
        for (genvar i = 0; i < DIGIT; i++) begin : g_bit
            assign s[i]     = a[i] ^ b[i] ^ w_c[i];
            assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
        end
    endgenerate

    assign co    = w_c[DIGIT];
    // Carry into the top bit of this digit; becomes the carry into the MSB on the last step.
    assign c_top = w_c[DIGIT-1];

endmodule : adder_digit
`default_nettype wire

// File: rtl/serial_adder_n.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder_n
// Brief    : Multi-cycle add/subtract, DIGIT bits per clock, with carry-out,
//            signed overflow and a one-cycle done pulse.
// Revision : 1.0
// ============================================================================
module serial_adder_n
    import adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int STEPS = WIDTH / DIGIT;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(STEPS - 1);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout;
    logic             r_ovf;

    logic [DIGIT-1:0] w_ds;
    logic             w_dco;
    logic             w_dctop;
    logic             w_accept;
    logic             w_last;
    logic [WIDTH-1:0] w_acc_next;

    adder_digit #(.DIGIT(DIGIT)) u_digit (
        .a     (r_a[DIGIT-1:0]),
        .b     (r_b[DIGIT-1:0]),
        .ci    (r_carry),
        .s     (w_ds),
        .co    (w_dco),
        .c_top (w_dctop)
    );

    assign w_accept   = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_last     = (r_state == ST_RUN) && (r_cnt == C_LAST);
    // New digit enters at the top so the LSB digit ends at bit 0 after STEPS shifts.
    assign w_acc_next = (r_acc >> DIGIT) | (WIDTH'(w_ds) << (WIDTH - DIGIT));

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (start) w_next = ST_RUN;
            ST_RUN:  if (r_cnt == C_LAST) w_next = ST_DONE;
            ST_DONE: w_next = start ? ST_RUN : ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_a     <= x;
            r_b     <= (sub == MODE_SUB) ? ~y : y;
            r_carry <= (sub == MODE_SUB) ? 1'b1 : cin;
            r_cnt   <= '0;
        end else if (r_state == ST_RUN) begin
            r_a     <= r_a >> DIGIT;
            r_b     <= r_b >> DIGIT;
            r_acc   <= w_acc_next;
            r_carry <= w_dco;
            r_cnt   <= r_cnt + 1'b1;
            if (w_last) begin
                r_sum  <= w_acc_next;
                r_cout <= w_dco;
                r_ovf  <= w_dco ^ w_dctop;
            end
        end
    end

    assign busy = (r_state == ST_RUN);
    assign done = (r_state == ST_DONE);
    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule : serial_adder_n
`default_nettype wire
